dbus_mmio_responder: RTL and testbench
======================================

# dbus_mmio_responder

Data-side responder for the MiniMIPS32 data port: answers the core's `dce`/`daddr`/`we`/`din`/`dm` requests with the same one-cycle synchronous-read behaviour as the data block RAM. It serves a small scratch RAM plus a memory-mapped register bank containing an LED output register and a 32-bit compare timer with a level interrupt. It sits at SoC top level, next to or in place of the data RAM, on the 50 MHz CPU clock.

## Interface
Parameters:
- `RAM_AW`, 8: scratch RAM word-address width; 2^RAM_AW 32-bit words.
- `LED_W`, 16: width of the LED output register, 1..32.

Ports:
- `cpu_clk_50M` in 1: sole clock; all state changes on its rising edge.
- `cpu_rst_n` in 1: asynchronous active-low reset.
- `dce` in 1: access enable from the core.
- `daddr` in 32: byte address; bits [1:0] ignored.
- `we` in 4: byte-lane write enables; lane i covers `din[8i+7:8i]`. Zero means read.
- `din` in 32: write data.
- `dm` out 32: registered read data to the core.
- `led` out LED_W: LED register contents.
- `timer_irq` out 1: timer interrupt request, level.

## Operation
- Decode, with all address bits above bit 12 ignored:
  - `daddr[12]=0`: scratch RAM, word index `daddr[RAM_AW+1:2]`.
  - `daddr[12]=1`: register bank, index `daddr[4:2]`.
- Registers:
  - 0 LED: RW, low LED_W bits; upper bits read 0.
  - 1 COUNT: RW.
  - 2 COMPARE: RW.
  - 3 STATUS: bit0 PEND; writing 1 clears it, writing 0 has no effect.
  - 4 CTRL: bit0 EN, bit1 AUTORELOAD, bit2 IE.
  - 5–7: read 0, writes ignored.
- Byte writes: every register and RAM word honours `we` per lane. Unwritten lanes keep their value.
- Access is active only when `dce=1`. With `dce=0`, `we` and `din` are ignored.
- Timer, evaluated each cycle when EN=1:
  - If COUNT == COMPARE: set PEND; COUNT becomes 0 if AUTORELOAD, else COUNT+1.
  - Otherwise COUNT becomes COUNT+1.
  - Increment wraps 0xFFFFFFFF → 0 and does not set PEND by itself.
  - When EN=0, COUNT holds.
- `timer_irq` = PEND & IE, from registered state with no combinational path from inputs.
- Simultaneous events:
  - CPU write to COUNT (any lane) overrides increment and reload that cycle; lanes not written take the value the timer would have produced.
  - PEND set and PEND clear in the same cycle: set wins.
  - Compare match is evaluated on pre-write COUNT.

## Timing
- Read latency is 1 cycle. A request sampled with `dce=1` at edge N drives `dm` after edge N, and it stays valid until the next access.
- `dm` holds its last value while `dce=0`.
- Write access: `dm` returns the pre-write contents of the addressed word (read-first). Written data is visible to a read issued at edge N+1.
- COUNT read at edge N returns the value before that edge's update.
- Back-to-back accesses every cycle are supported; there are no wait states and no stall output.
- Reset values:
  - `dm` = 0, `led` = 0, `timer_irq` = 0.
  - COUNT = 0, COMPARE = 0xFFFFFFFF, STATUS = 0, CTRL = 0.
  - Scratch RAM contents are not reset.
- Reset mid-operation: assertion clears all registers and outputs immediately, regardless of clock. A write in flight is dropped. The first access is accepted at the first rising edge after deassertion.

## Configuration
- `MMIO_TIMER_EN` defined: timer present as described.
- Undefined:
  - COUNT, COMPARE and STATUS read 0 and ignore writes.
  - CTRL bits 0–2 read 0.
  - `timer_irq` is tied 0.
  - No timer flops are synthesised.
  - LED and scratch RAM behaviour is unchanged.

## Test plan
- RAM byte write: write 0xAABBCCDD to 0x40 with `we`=4'b1111, then `we`=4'b0010 with `din`=0x00001100; read 0x40 → `dm`=0xAABB11DD one cycle after the read edge.
- Read-first and hold: read 0x40, then write 0x12345678 to 0x40 → the write cycle's `dm` is the old value; drop `dce` for 3 cycles → `dm` stable.
- LED and decode: write 0xFFFF1234 to 0x1000 with LED_W=16 → `led`=0x1234, read back 0x00001234. Write to 0x101C → no effect, reads 0. Write to 0x3000 aliases 0x1000.
- Timer match and autoreload: COMPARE=5, CTRL=7 → PEND sets when COUNT=5, COUNT goes to 0, and `timer_irq` rises the following cycle. Writing 1 to STATUS on the same cycle as a match → PEND stays 1.
- Wrap: COUNT=0xFFFFFFFE, COMPARE=3, CTRL=1 → COUNT steps to 0xFFFFFFFF, 0, 1 with no PEND until COUNT=3.
- Async reset: assert `cpu_rst_n` mid-write while the timer is running → `led`, `dm`, `timer_irq` and COUNT are 0 before the next edge, and COMPARE reads 0xFFFFFFFF after release. Build without `MMIO_TIMER_EN` → COUNT reads 0 and `timer_irq` stays 0.

Source files
------------

// File: rtl/dbus_mmio_responder.sv
// dbus_mmio_responder
//   Data-side responder for the MiniMIPS32 data port. Mimics a synchronous
//   block RAM (one-cycle registered read, read-first on write). It serves a
//   scratch RAM (daddr[12]=0) and a small register bank (daddr[12]=1) with
//   an LED register and an optional 32-bit compare timer.
//
//   Build option: define MMIO_TIMER_EN to include the compare timer.
//   Without it, COUNT/COMPARE/STATUS/CTRL read 0 and timer_irq is tied low.
//
// Ports:
//   cpu_clk_50M  in   sole clock, rising edge
//   cpu_rst_n    in   asynchronous active-low reset
//   dce          in   access enable
//   daddr[31:0]  in   byte address (bits [1:0] and above 12 ignored)
//   we[3:0]      in   byte-lane write enables, 0 = read
//   din[31:0]    in   write data
//   dm[31:0]     out  registered read data
//   led[LED_W-1:0] out LED register
//   timer_irq    out  level interrupt, PEND & IE
module dbus_mmio_responder #(
  parameter int RAM_AW = 8,
  parameter int LED_W  = 16
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst_n,
  input  logic             dce,
  input  logic [31:0]      daddr,
  input  logic [3:0]       we,
  input  logic [31:0]      din,
  output logic [31:0]      dm,
  output logic [LED_W-1:0] led,
  output logic             timer_irq
);

  localparam logic [2:0] REG_LED     = 3'd0;
  localparam logic [2:0] REG_COUNT   = 3'd1;
  localparam logic [2:0] REG_COMPARE = 3'd2;
  localparam logic [2:0] REG_STATUS  = 3'd3;
  localparam logic [2:0] REG_CTRL    = 3'd4;

  // Replace the lanes selected by lane_we with new_val, keep the rest.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  lane_we);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = lane_we[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

  logic                sel_reg_s;
  logic [2:0]          reg_idx_s;
  logic [RAM_AW-1:0]   ram_idx_s;
  logic                ram_wr_s;
  logic                wr_led_s;
  logic [31:0]         led_ext_s;
  logic [31:0]         led_wdata_s;
  logic [31:0]         rd_data_s;
  logic [31:0]         dm_r;
  logic [LED_W-1:0]    led_r;
  logic [31:0]         mem_r [0:(1<<RAM_AW)-1];
  logic                unused_s;

  assign sel_reg_s = daddr[12];
  assign reg_idx_s = daddr[4:2];
  assign ram_idx_s = daddr[RAM_AW+1:2];
  // Gated by reset so a write caught by reset assertion never lands.
  assign ram_wr_s  = cpu_rst_n & dce & ~sel_reg_s & (|we);
  assign wr_led_s  = dce & sel_reg_s & (reg_idx_s == REG_LED);

  // Zero-extend the LED register to a bus word and build its write value.
  always_comb begin
    led_ext_s              = 32'd0;
    led_ext_s[LED_W-1:0]   = led_r;
    led_wdata_s            = merge_lanes(led_ext_s, din, we);
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] count_r, compare_r;
  logic [31:0] count_tmr_s, count_nxt_s, compare_nxt_s;
  logic [2:0]  ctrl_r, ctrl_nxt_s;
  logic        pend_r, pend_nxt_s, irq_r, match_s;
  logic        wr_count_s, wr_compare_s, wr_status_s, wr_ctrl_s;

  assign wr_count_s   = dce & sel_reg_s & (reg_idx_s == REG_COUNT);
  assign wr_compare_s = dce & sel_reg_s & (reg_idx_s == REG_COMPARE);
  assign wr_status_s  = dce & sel_reg_s & (reg_idx_s == REG_STATUS);
  assign wr_ctrl_s    = dce & sel_reg_s & (reg_idx_s == REG_CTRL);

  // Timer next state; CPU lanes override the timer, match uses pre-write COUNT.
  always_comb begin
    match_s = ctrl_r[0] && (count_r == compare_r);
    if (ctrl_r[0]) begin
      if (match_s && ctrl_r[1]) begin
        count_tmr_s = 32'd0;
      end else begin
        count_tmr_s = count_r + 32'd1;
      end
    end else begin
      count_tmr_s = count_r;
    end
    if (wr_count_s) begin
      count_nxt_s = merge_lanes(count_tmr_s, din, we);
    end else begin
      count_nxt_s = count_tmr_s;
    end
    if (wr_compare_s) begin
      compare_nxt_s = merge_lanes(compare_r, din, we);
    end else begin
      compare_nxt_s = compare_r;
    end
    // Set beats write-1-to-clear in the same cycle.
    if (match_s) begin
      pend_nxt_s = 1'b1;
    end else if (wr_status_s && we[0] && din[0]) begin
      pend_nxt_s = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end
    if (wr_ctrl_s && we[0]) begin
      ctrl_nxt_s = din[2:0];
    end else begin
      ctrl_nxt_s = ctrl_r;
    end
  end

  // Timer state and the registered interrupt (mirrors PEND & IE exactly).
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      count_r   <= 32'd0;
      compare_r <= 32'hFFFF_FFFF;
      pend_r    <= 1'b0;
      ctrl_r    <= 3'd0;
      irq_r     <= 1'b0;
    end else begin
      count_r   <= count_nxt_s;
      compare_r <= compare_nxt_s;
      pend_r    <= pend_nxt_s;
      ctrl_r    <= ctrl_nxt_s;
      irq_r     <= pend_nxt_s & ctrl_nxt_s[2];
    end
  end

  assign timer_irq = irq_r;
`else
  assign timer_irq = 1'b0;
`endif

  // Read data mux for the addressed word (pre-write contents).
  always_comb begin
    rd_data_s = 32'd0;
    if (sel_reg_s) begin
      case (reg_idx_s)
        REG_LED:     rd_data_s = led_ext_s;
`ifdef MMIO_TIMER_EN
        REG_COUNT:   rd_data_s = count_r;
        REG_COMPARE: rd_data_s = compare_r;
        REG_STATUS:  rd_data_s = {31'd0, pend_r};
        REG_CTRL:    rd_data_s = {29'd0, ctrl_r};
`endif
        default:     rd_data_s = 32'd0;
      endcase
    end else begin
      rd_data_s = mem_r[ram_idx_s];
    end
  end

  // Scratch RAM write port; contents are deliberately not reset.
  always_ff @(posedge cpu_clk_50M) begin
    if (ram_wr_s) begin
      mem_r[ram_idx_s] <= merge_lanes(mem_r[ram_idx_s], din, we);
    end
  end

  // Registered read data; holds while the core is idle.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      dm_r <= 32'd0;
    end else if (dce) begin
      dm_r <= rd_data_s;
    end
  end

  // LED output register.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      led_r <= '0;
    end else if (wr_led_s) begin
      led_r <= led_wdata_s[LED_W-1:0];
    end
  end

  assign dm  = dm_r;
  assign led = led_r;

  // Address bits outside the decode and LED padding lanes are don't-care.
  assign unused_s = ^{daddr, led_wdata_s};

endmodule

// File: tb/tb_dbus_mmio_responder.sv
module tb_dbus_mmio_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dce = 1'b0;
  logic [31:0] daddr = 32'd0;
  logic [3:0]  we = 4'd0;
  logic [31:0] din = 32'd0;
  logic [31:0] dm;
  logic [15:0] led;
  logic        timer_irq;

  int n_checks = 0;
  int n_errors = 0;

  dbus_mmio_responder #(.RAM_AW(8), .LED_W(16)) dut (
    .cpu_clk_50M (clk),
    .cpu_rst_n   (rst_n),
    .dce         (dce),
    .daddr       (daddr),
    .we          (we),
    .din         (din),
    .dm          (dm),
    .led         (led),
    .timer_irq   (timer_irq)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, return 1 time unit after the rising edge.
  task automatic bus(input logic en, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    @(negedge clk);
    dce = en; daddr = a; we = w; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    bus(1'b1, a, w, d);
  endtask

  task automatic rd(input logic [31:0] a);
    bus(1'b1, a, 4'd0, 32'd0);
  endtask

  task automatic idle();
    bus(1'b0, 32'h0000_1000, 4'hF, 32'h0000_0000);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_dm", dm, 32'd0);
    check_eq("rst_led", 32'(led), 32'd0);
    check_eq("rst_irq", 32'(timer_irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // RAM byte writes and read-first
    wr(32'h40, 4'hF, 32'hAABB_CCDD);
    wr(32'h40, 4'b0010, 32'h0000_1100);
    check_eq("ram_rdfirst_lane", dm, 32'hAABB_CCDD);
    rd(32'h40);
    check_eq("ram_lane_merge", dm, 32'hAABB_11DD);
    wr(32'h40, 4'hF, 32'h1234_5678);
    check_eq("ram_rdfirst", dm, 32'hAABB_11DD);
    for (int i = 0; i < 3; i++) begin
      idle();
      check_eq("dm_hold", dm, 32'hAABB_11DD);
    end
    rd(32'h40);
    check_eq("ram_new", dm, 32'h1234_5678);

    // LED register and decode
    wr(32'h1000, 4'hF, 32'hFFFF_1234);
    check_eq("led_wr", 32'(led), 32'h0000_1234);
    check_eq("led_rdfirst", dm, 32'd0);
    rd(32'h1000);
    check_eq("led_rd", dm, 32'h0000_1234);
    wr(32'h1000, 4'b0010, 32'h0000_AB00);
    check_eq("led_lane", 32'(led), 32'h0000_AB34);
    wr(32'h101C, 4'hF, 32'hDEAD_BEEF);
    rd(32'h101C);
    check_eq("reg7_rd0", dm, 32'd0);
    check_eq("reg7_noeff", 32'(led), 32'h0000_AB34);
    wr(32'h3000, 4'hF, 32'h0000_5678);
    check_eq("led_alias", 32'(led), 32'h0000_5678);
    rd(32'h1000);
    check_eq("led_rd2", dm, 32'h0000_5678);
    bus(1'b0, 32'h1000, 4'hF, 32'hFFFF_FFFF);
    check_eq("dce0_led", 32'(led), 32'h0000_5678);
    check_eq("dce0_dm", dm, 32'h0000_5678);
    rd(32'h2040);
    check_eq("ram_alias", dm, 32'h1234_5678);

`ifdef MMIO_TIMER_EN
    rd(32'h1008);
    check_eq("cmp_rst", dm, 32'hFFFF_FFFF);
    rd(32'h1010);
    check_eq("ctrl_rst", dm, 32'd0);
    // match with autoreload
    wr(32'h1008, 4'hF, 32'd5);
    wr(32'h1010, 4'hF, 32'd7);
    repeat (4) idle();
    check_eq("irq_pre", 32'(timer_irq), 32'd0);
    rd(32'h1004);
    check_eq("cnt4", dm, 32'd4);
    rd(32'h1004);
    check_eq("cnt5", dm, 32'd5);
    check_eq("irq_match", 32'(timer_irq), 32'd1);
    rd(32'h1004);
    check_eq("cnt_reload", dm, 32'd0);
    rd(32'h100C);
    check_eq("pend_set", dm, 32'd1);
    wr(32'h100C, 4'hF, 32'd1);
    check_eq("irq_clr", 32'(timer_irq), 32'd0);
    rd(32'h100C);
    check_eq("pend_clr", dm, 32'd0);
    idle();
    wr(32'h100C, 4'hF, 32'd1);
    check_eq("irq_setwins", 32'(timer_irq), 32'd1);
    rd(32'h100C);
    check_eq("pend_setwins", dm, 32'd1);
    // wrap without autoreload
    wr(32'h1010, 4'hF, 32'd0);
    wr(32'h100C, 4'hF, 32'd1);
    wr(32'h1008, 4'hF, 32'd3);
    wr(32'h1004, 4'hF, 32'hFFFF_FFFE);
    wr(32'h1010, 4'hF, 32'd1);
    rd(32'h1004);
    check_eq("wrap_fe", dm, 32'hFFFF_FFFE);
    rd(32'h1004);
    check_eq("wrap_ff", dm, 32'hFFFF_FFFF);
    rd(32'h1004);
    check_eq("wrap_0", dm, 32'd0);
    rd(32'h1004);
    check_eq("wrap_1", dm, 32'd1);
    rd(32'h100C);
    check_eq("wrap_nopend2", dm, 32'd0);
    rd(32'h100C);
    check_eq("wrap_nopend3", dm, 32'd0);
    rd(32'h100C);
    check_eq("wrap_pend", dm, 32'd1);
    // partial COUNT write while running
    wr(32'h1004, 4'b1110, 32'h1234_5600);
    rd(32'h1004);
    check_eq("cnt_lane_wr", dm, 32'h1234_5606);
    wr(32'h1010, 4'hF, 32'd7);
    check_eq("irq_ie", 32'(timer_irq), 32'd1);
`else
    wr(32'h1004, 4'hF, 32'd5);
    rd(32'h1004);
    check_eq("notmr_cnt", dm, 32'd0);
    wr(32'h1010, 4'hF, 32'd7);
    rd(32'h1010);
    check_eq("notmr_ctrl", dm, 32'd0);
    repeat (8) idle();
    check_eq("notmr_irq", 32'(timer_irq), 32'd0);
`endif

    // asynchronous reset in the middle of a write
    @(negedge clk);
    dce = 1'b1; daddr = 32'h1000; we = 4'hF; din = 32'h0000_BEEF;
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_led", 32'(led), 32'd0);
    check_eq("arst_dm", dm, 32'd0);
    check_eq("arst_irq", 32'(timer_irq), 32'd0);
`ifdef MMIO_TIMER_EN
    check_eq("arst_cnt", dut.count_r, 32'd0);
`endif
    @(posedge clk);
    #1;
    dce = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(32'h1000);
    check_eq("arst_drop", dm, 32'd0);
`ifdef MMIO_TIMER_EN
    rd(32'h1008);
    check_eq("arst_cmp", dm, 32'hFFFF_FFFF);
    rd(32'h1004);
    check_eq("arst_cnt_rd", dm, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
